// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: one MAC per cycle over N_IN taps for each of N_OUT neurons,
// weights/biases from an external synchronous ROM. Define FC_RELU_EN to clamp results at zero.
module fc_layer_seq #(
  parameter int BW     = 8,
  parameter int N_IN   = 100,
  parameter int N_OUT  = 10,
  parameter int ACC_BW = 24
) (
  input  logic                              clk,
  input  logic                              global_rst_n,
  input  logic                              rst_processEnd,
  input  logic                              i_full,
  input  logic [N_IN*BW-1:0]                i_data,
  output logic [$clog2(N_IN*N_OUT)-1:0]     o_w_addr,
  input  logic [BW-1:0]                     i_w_data,
  output logic [$clog2(N_OUT)-1:0]          o_b_addr,
  input  logic [BW-1:0]                     i_b_data,
  output logic [ACC_BW-1:0]                 o_data,
  output logic                              o_valid,
  output logic [$clog2(N_OUT)-1:0]          o_idx,
  output logic                              o_done
);

  localparam int AW = $clog2(N_IN*N_OUT);
  localparam int NW = $clog2(N_OUT);
  localparam int KW = $clog2(N_IN+1);

  typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} state_t;

  state_t                    state, state_nxt;
  logic [NW-1:0]             n;
  logic [KW-1:0]             k;
  logic [AW-1:0]             base;
  logic signed [ACC_BW-1:0]  acc;

  logic [KW-1:0]             tap;
  int                        tap_i;
  logic signed [BW-1:0]      x_sel;
  logic signed [2*BW-1:0]    x_ext, w_ext, prod;
  logic signed [ACC_BW-1:0]  prod_ext, bias_ext, sum;

  function automatic logic signed [ACC_BW-1:0] relu(input logic signed [ACC_BW-1:0] v);
`ifdef FC_RELU_EN
    return v[ACC_BW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Tap k consumes x[k-1] with the weight the ROM returns for address issued at k-1.
  always_comb begin
    tap      = (k == '0) ? '0 : k - KW'(1);
    tap_i    = int'(tap);
    x_sel    = i_data[tap_i*BW +: BW];
    x_ext    = {{BW{x_sel[BW-1]}}, x_sel};
    w_ext    = {{BW{i_w_data[BW-1]}}, i_w_data};
    prod     = x_ext * w_ext;
    prod_ext = {{(ACC_BW-2*BW){prod[2*BW-1]}}, prod};
    bias_ext = {{(ACC_BW-BW){i_b_data[BW-1]}}, i_b_data};
    sum      = (k == KW'(1)) ? bias_ext + prod_ext : acc + prod_ext;
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_w_addr  = '0;
    o_b_addr  = '0;
    case (state)
      IDLE: if (i_full) state_nxt = RUN;
      RUN: begin
        o_b_addr = n;
        if (k != KW'(N_IN)) o_w_addr = base + AW'(k);
        else                state_nxt = EMIT;
      end
      EMIT: state_nxt = (n == NW'(N_OUT-1)) ? DONE : RUN;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (rst_processEnd) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      n       <= '0;
      k       <= '0;
      base    <= '0;
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_idx   <= '0;
      o_done  <= 1'b0;
    end else if (rst_processEnd) begin
      n       <= '0;
      k       <= '0;
      base    <= '0;
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_idx   <= '0;
      o_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_full) begin
          n    <= '0;
          k    <= '0;
          base <= '0;
        end
        RUN: begin
          if (k != '0) acc <= sum;
          if (k == KW'(N_IN)) begin
            o_data  <= relu(sum);
            o_idx   <= n;
            o_valid <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        EMIT: begin
          o_valid <= 1'b0;
          if (n == NW'(N_OUT-1)) begin
            o_done <= 1'b1;
          end else begin
            n    <= n + NW'(1);
            k    <= '0;
            base <= base + AW'(N_IN);
          end
        end
        DONE: o_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq with a synchronous weight/bias ROM model.
module tb_fc_layer_seq;

  localparam int BW = 8, N_IN = 100, N_OUT = 10, ACC_BW = 24;

  logic                clk = 1'b0;
  logic                global_rst_n, rst_processEnd, i_full;
  logic [N_IN*BW-1:0]  i_data;
  logic [9:0]          o_w_addr;
  logic [BW-1:0]       i_w_data;
  logic [3:0]          o_b_addr;
  logic [BW-1:0]       i_b_data;
  logic [ACC_BW-1:0]   o_data;
  logic                o_valid;
  logic [3:0]          o_idx;
  logic                o_done;

  logic [BW-1:0] wrom [0:N_IN*N_OUT-1];
  logic [BW-1:0] brom [0:15];

  fc_layer_seq #(.BW(BW), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_BW(ACC_BW)) dut (
    .clk(clk), .global_rst_n(global_rst_n), .rst_processEnd(rst_processEnd),
    .i_full(i_full), .i_data(i_data), .o_w_addr(o_w_addr), .i_w_data(i_w_data),
    .o_b_addr(o_b_addr), .i_b_data(i_b_data), .o_data(o_data), .o_valid(o_valid),
    .o_idx(o_idx), .o_done(o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    i_w_data <= wrom[o_w_addr];
    i_b_data <= brom[o_b_addr];
  end

  // Neuron n uses weight (w_n ? n : w) and bias (b_n ? n : b); expected = e0 + en*n.
  typedef struct {
    logic signed [7:0] x;
    logic signed [7:0] w;
    logic              w_n;
    logic signed [7:0] b;
    logic              b_n;
    int                e0;
    int                en;
  } vec_t;

  vec_t vecs [6];
  int total = 0;
  int bad   = 0;

  function automatic int rl(input int v);
`ifdef FC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic load(input int vi);
    for (int n = 0; n < N_OUT; n++) begin
      for (int k = 0; k < N_IN; k++)
        wrom[n*N_IN+k] = vecs[vi].w_n ? 8'(n) : vecs[vi].w;
      brom[n] = vecs[vi].b_n ? 8'(n) : vecs[vi].b;
    end
    for (int k = 0; k < N_IN; k++) i_data[k*BW +: BW] = vecs[vi].x;
  endtask

  task automatic clear_frame();
    @(negedge clk);
    i_full         = 1'b0;
    rst_processEnd = 1'b1;
    @(negedge clk);
    rst_processEnd = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    i_full = 1'b1;
    @(posedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_data"},  int'(o_data),   0);
    chk({tag, "_valid"}, int'(o_valid),  0);
    chk({tag, "_idx"},   int'(o_idx),    0);
    chk({tag, "_done"},  int'(o_done),   0);
    chk({tag, "_waddr"}, int'(o_w_addr), 0);
    chk({tag, "_baddr"}, int'(o_b_addr), 0);
  endtask

  // Called just after the edge E0 that sampled i_full=1; t counts edges since E0.
  task automatic check_frame(input int vi);
    int extra, addr_err, m, kk, got;
    extra = 0;
    addr_err = 0;
    for (int t = 0; t <= 1020; t++) begin
      if (t > 0) @(posedge clk);
      #1;
      m  = t / 102;
      kk = t % 102;
      if (t < 1020 && kk <= 99) begin
        if (int'(o_w_addr) != m*N_IN + kk) addr_err++;
        if (kk == 0 && int'(o_b_addr) != m) addr_err++;
      end
      if (t < 1020 && kk == 101) begin
        got = $signed(o_data);
        chk($sformatf("v%0d_valid_n%0d", vi, m), int'(o_valid), 1);
        chk($sformatf("v%0d_idx_n%0d", vi, m), int'(o_idx), m);
        chk($sformatf("v%0d_data_n%0d", vi, m), got, rl(vecs[vi].e0 + vecs[vi].en*m));
      end else if (o_valid) begin
        extra++;
      end
      if (t == 1019) chk($sformatf("v%0d_done_early", vi), int'(o_done), 0);
    end
    chk($sformatf("v%0d_done", vi), int'(o_done), 1);
    chk($sformatf("v%0d_extra_strobes", vi), extra, 0);
    chk($sformatf("v%0d_addr_seq_errors", vi), addr_err, 0);
  endtask

  initial begin
    vecs[0] = '{x:  1,   w:  1,   w_n: 0, b:  0,   b_n: 0, e0: 100,      en: 0};
    vecs[1] = '{x: -128, w:  127, w_n: 0, b: -5,   b_n: 0, e0: -1625605, en: 0};
    vecs[2] = '{x:  2,   w:  0,   w_n: 1, b:  0,   b_n: 1, e0: 0,        en: 201};
    vecs[3] = '{x: -1,   w:  3,   w_n: 0, b:  7,   b_n: 0, e0: -293,     en: 0};
    vecs[4] = '{x:  127, w: -128, w_n: 0, b:  127, b_n: 0, e0: -1625473, en: 0};
    vecs[5] = '{x: -128, w: -128, w_n: 0, b: -128, b_n: 0, e0: 1638272,  en: 0};

    global_rst_n   = 1'b0;
    rst_processEnd = 1'b0;
    i_full         = 1'b0;
    load(0);
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    global_rst_n = 1'b1;

    for (int vi = 0; vi < 6; vi++) begin
      clear_frame();
      load(vi);
      start_frame();
      check_frame(vi);
    end

    begin : hold_after_done
      int strobes, not_done, addr_nz;
      strobes = 0; not_done = 0; addr_nz = 0;
      for (int c = 0; c < 500; c++) begin
        @(posedge clk);
        #1;
        if (o_valid) strobes++;
        if (!o_done) not_done++;
        if (o_w_addr != '0 || o_b_addr != '0) addr_nz++;
      end
      chk("hold_strobes", strobes, 0);
      chk("hold_not_done", not_done, 0);
      chk("hold_addr_nonzero", addr_nz, 0);
    end

    clear_frame();
    load(0);
    start_frame();
    repeat (346) @(posedge clk);
    @(negedge clk);
    rst_processEnd = 1'b1;
    @(posedge clk);
    #1;
    chk_zero_outputs("pe_clear");
    @(negedge clk);
    rst_processEnd = 1'b0;
    @(posedge clk);
    check_frame(0);

    clear_frame();
    load(0);
    start_frame();
    repeat (150) @(posedge clk);
    #3;
    global_rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    @(negedge clk);
    global_rst_n = 1'b1;
    @(posedge clk);
    check_frame(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
